game_move_sequencer: RTL and testbench

Transmit-side driver for the six-player turn game: accepts queued moves (player index + 3-bit move code) over a valid/ready handshake and replays each one onto the game's six `playerN` buses and one-hot `player_clk` strobes with guaranteed setup, pulse and gap timing. After every strobe it samples the game's `state_out`. When it sees a loser state, it stops, flushes its queue and reports the losing player. It sits between a test/CPU front end and the game core, so scripted matches can run without hand-toggled switches.

---
 rtl/game_move_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_game_move_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_move_sequencer.sv
// game_move_sequencer: buffers player moves in a small FIFO and replays each
// one onto the game's per-player buses with a setup cycle, a strobe pulse and
// a recovery gap, then checks the game state for a loser.
module game_move_sequencer #(
    parameter int DEPTH     = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_valid,
    input  logic [2:0] move_player,
    input  logic [2:0] move_code,
    output logic       move_ready,
    input  logic       restart,
    input  logic [3:0] state_out,
    output logic [2:0] player1,
    output logic [2:0] player2,
    output logic [2:0] player3,
    output logic [2:0] player4,
    output logic [2:0] player5,
    output logic [2:0] player6,
    output logic [5:0] player_clk,
    output logic       busy,
    output logic       game_over,
    output logic [2:0] loser,
    output logic       bad_move,
    output logic [7:0] moves_sent
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_RECOVER,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_pop;
    logic            w_push;
    logic            w_push_ok;
    logic            w_push_bad;
    logic            w_flush;
    logic [5:0]      w_head;

    logic [5:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_tmr;
    logic [2:0]      r_cur_player;
    logic [2:0]      r_bus [6];
    logic [5:0]      r_pclk;
    logic            r_busy;
    logic            r_game_over;
    logic [2:0]      r_loser;
    logic            r_bad_move;
    logic [7:0]      r_moves_sent;

    // Saturating strobe counter increment.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // One-hot strobe for a player index 1..6; anything else yields no strobe.
    function automatic logic [5:0] strobe_of(input logic [2:0] p);
        case (p)
            3'd1:    return 6'b000001;
            3'd2:    return 6'b000010;
            3'd3:    return 6'b000100;
            3'd4:    return 6'b001000;
            3'd5:    return 6'b010000;
            3'd6:    return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    assign move_ready = (r_count < FULL) & ~r_game_over;
    assign w_push     = move_valid & move_ready;
    assign w_push_bad = w_push & ((move_player == 3'd0) | (move_player == 3'd7));
    assign w_push_ok  = w_push & ~w_push_bad;
    assign w_head     = r_mem[r_rptr];
    assign w_flush    = (r_state == S_RECOVER) & (w_state_nxt == S_DONE);

    assign player1    = r_bus[0];
    assign player2    = r_bus[1];
    assign player3    = r_bus[2];
    assign player4    = r_bus[3];
    assign player5    = r_bus[4];
    assign player6    = r_bus[5];
    assign player_clk = r_pclk;
    assign busy       = r_busy;
    assign game_over  = r_game_over;
    assign loser      = r_loser;
    assign bad_move   = r_bad_move;
    assign moves_sent = r_moves_sent;

    // Next-state logic: sequence setup/pulse/recover per move; restart always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP:   w_state_nxt = S_PULSE;
            S_PULSE:   if (r_tmr == '0) w_state_nxt = S_RECOVER;
            S_RECOVER: if (r_tmr == '0) w_state_nxt = state_out[3] ? S_DONE : S_IDLE;
            S_DONE:    w_state_nxt = S_DONE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (restart) begin
            w_state_nxt = S_IDLE;
            w_pop       = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Phase timer: loaded on entry to PULSE and RECOVER, counts down to zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tmr <= '0;
        end else if (r_state == S_SETUP && w_state_nxt == S_PULSE) begin
            r_tmr <= TW'(PULSE_LEN - 1);
        end else if (r_state == S_PULSE && w_state_nxt == S_RECOVER) begin
            r_tmr <= TW'(GAP_LEN - 1);
        end else if (r_tmr != '0) begin
            r_tmr <= r_tmr - TW'(1);
        end
    end

    // FIFO storage; only valid player indices are written.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= {move_player, move_code};
    end

    // FIFO pointers and occupancy; restart and loser detection flush everything.
    always_ff @(posedge clk) begin
        if (!reset_n || restart || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop)     r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
        end
    end

    // Registered outputs: bus, strobe, status and counters follow the phase.
    always_ff @(posedge clk) begin
        if (!reset_n || restart) begin
            for (int k = 0; k < 6; k++) r_bus[k] <= 3'd0;
            r_pclk       <= 6'd0;
            r_busy       <= 1'b0;
            r_game_over  <= 1'b0;
            r_loser      <= 3'd0;
            r_bad_move   <= 1'b0;
            r_moves_sent <= 8'd0;
            r_cur_player <= 3'd0;
        end else begin
            r_bad_move <= w_push_bad;
            r_busy     <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_PULSE) ||
                          (w_state_nxt == S_RECOVER);
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cur_player <= w_head[5:3];
                        for (int k = 0; k < 6; k++)
                            r_bus[k] <= (w_head[5:3] == 3'(k + 1)) ? w_head[2:0] : 3'd0;
                    end
                end
                S_SETUP: begin
                    r_pclk       <= strobe_of(r_cur_player);
                    r_moves_sent <= sat_inc(r_moves_sent);
                end
                S_PULSE: begin
                    if (r_tmr == '0) r_pclk <= 6'd0;
                end
                S_RECOVER: begin
                    if (r_tmr == '0) begin
                        for (int k = 0; k < 6; k++) r_bus[k] <= 3'd0;
                        if (state_out[3]) begin
                            r_game_over <= 1'b1;
                            r_loser     <= state_out[2:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_move_sequencer.sv
// tb_game_move_sequencer: drives directed and random move traffic into
// game_move_sequencer and compares every output each cycle with a
// queue-and-phase reference model of the move replay rules.
module tb_game_move_sequencer;

    localparam int DEPTH = 4;
    localparam int PL    = 2;
    localparam int GL    = 2;
    localparam int L     = 1 + PL + GL;   // cycles from SETUP to last sample cycle

    logic       clk;
    logic       reset_n;
    logic       move_valid;
    logic [2:0] move_player;
    logic [2:0] move_code;
    logic       move_ready;
    logic       restart;
    logic [3:0] state_out;
    logic [2:0] player1, player2, player3, player4, player5, player6;
    logic [5:0] player_clk;
    logic       busy;
    logic       game_over;
    logic [2:0] loser;
    logic       bad_move;
    logic [7:0] moves_sent;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [5:0] mq[$];
    int         ph;        // -1: not moving a player; 0: setup; 1..PL: pulse; PL+1..L-1: gap
    logic [2:0] m_p, m_c;
    logic       m_go;
    logic [2:0] m_loser;
    int         m_sent;
    logic       m_bad;

    game_move_sequencer #(.DEPTH(DEPTH), .PULSE_LEN(PL), .GAP_LEN(GL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .move_valid (move_valid),
        .move_player(move_player),
        .move_code  (move_code),
        .move_ready (move_ready),
        .restart    (restart),
        .state_out  (state_out),
        .player1    (player1),
        .player2    (player2),
        .player3    (player3),
        .player4    (player4),
        .player5    (player5),
        .player6    (player6),
        .player_clk (player_clk),
        .busy       (busy),
        .game_over  (game_over),
        .loser      (loser),
        .bad_move   (bad_move),
        .moves_sent (moves_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && !m_go;
    endfunction

    task automatic model_reset();
        mq.delete();
        ph      = -1;
        m_p     = 3'd0;
        m_c     = 3'd0;
        m_go    = 1'b0;
        m_loser = 3'd0;
        m_sent  = 0;
        m_bad   = 1'b0;
    endtask

    // advance the model by one clock given the inputs presented this cycle
    task automatic model_adv(input logic v, input logic [2:0] p, input logic [2:0] c,
                             input logic r, input logic [3:0] s);
        logic push;
        logic flush;
        logic [5:0] e;
        if (r) begin
            model_reset();
            return;
        end
        push  = v && m_ready();
        flush = 1'b0;
        if (ph == -1) begin
            if (!m_go && mq.size() > 0) begin
                e   = mq.pop_front();
                m_p = e[5:3];
                m_c = e[2:0];
                ph  = 0;
            end
        end else if (ph == L - 1) begin
            ph = -1;
            if (s[3]) begin
                m_go    = 1'b1;
                m_loser = s[2:0];
                flush   = 1'b1;
            end
        end else begin
            if (ph == 0 && m_sent < 255) m_sent++;
            ph++;
        end
        m_bad = push && (p == 3'd0 || p == 3'd7);
        if (push && !m_bad && !flush) mq.push_back({p, c});
        if (flush) mq.delete();
    endtask

    task automatic check_outputs();
        logic [17:0] eb;
        logic [5:0]  es;
        eb = '0;
        es = '0;
        for (int k = 0; k < 6; k++)
            if (ph >= 0 && m_p == 3'(k + 1)) eb[k*3 +: 3] = m_c;
        if (ph >= 1 && ph <= PL) es = 6'd1 << (m_p - 3'd1);
        chk("buses",      {player6, player5, player4, player3, player2, player1}, eb);
        chk("player_clk", player_clk, es);
        chk("onehot",     $countones(player_clk) <= 1, 1);
        chk("busy",       busy, ph >= 0);
        chk("game_over",  game_over, m_go);
        chk("loser",      loser, m_loser);
        chk("bad_move",   bad_move, m_bad);
        chk("moves_sent", moves_sent, m_sent);
        chk("move_ready", move_ready, m_ready());
    endtask

    task automatic step(input logic v, input logic [2:0] p, input logic [2:0] c,
                        input logic r, input logic [3:0] s);
        move_valid  = v;
        move_player = p;
        move_code   = c;
        restart     = r;
        state_out   = s;
        model_adv(v, p, c, r, s);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 1'b0, 4'd0);
    endtask

    // hold the move offered until the model says it is taken
    task automatic push_move(input logic [2:0] p, input logic [2:0] c);
        int n;
        n = 0;
        while (!m_ready() && n < 200) begin
            step(1'b1, p, c, 1'b0, 4'd0);
            n++;
        end
        if (n == 200) chk("push_timeout", 1, 0);
        else          step(1'b1, p, c, 1'b0, 4'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ph != -1 || (mq.size() > 0 && !m_go)) && n < 2000) begin
            idle(1);
            n++;
        end
        if (n == 2000) chk("drain_timeout", 1, 0);
        idle(1);
    endtask

    task automatic wait_phase(input int target);
        int n;
        n = 0;
        while (ph != target && n < 200) begin
            idle(1);
            n++;
        end
        if (n == 200) chk("phase_timeout", 1, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        move_valid  = 1'b0;
        move_player = 3'd0;
        move_code   = 3'd0;
        restart     = 1'b0;
        state_out   = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs();

        // quiet after reset
        idle(20);

        // single move to player 1
        push_move(3'd1, 3'd1);
        drain();
        chk("single_sent", moves_sent, 8'd1);

        // six back-to-back moves through a four-entry FIFO
        for (int i = 1; i <= 6; i++) push_move(3'(i), 3'(i) ^ 3'b101);
        drain();

        // loser reported with two moves still queued
        push_move(3'd2, 3'd5);
        push_move(3'd3, 3'd6);
        push_move(3'd4, 3'd7);
        wait_phase(L - 1);
        step(1'b0, 3'd0, 3'd0, 1'b0, 4'b1011);
        idle(12);
        chk("loser_go",    game_over, 1'b1);
        chk("loser_idx",   loser, 3'd3);
        chk("loser_ready", move_ready, 1'b0);
        step(1'b0, 3'd0, 3'd0, 1'b1, 4'd0);
        idle(3);

        // restart on the first pulse cycle
        push_move(3'd5, 3'd3);
        wait_phase(1);
        step(1'b0, 3'd0, 3'd0, 1'b1, 4'd0);
        chk("rst_clk",  player_clk, 6'd0);
        chk("rst_sent", moves_sent, 8'd0);
        idle(10);

        // invalid player indices
        push_move(3'd7, 3'd1);
        push_move(3'd0, 3'd2);
        idle(10);

        // saturate the strobe counter
        for (int i = 0; i < 260; i++) push_move(3'((i % 6) + 1), 3'(i));
        drain();
        chk("sat_sent", moves_sent, 8'd255);
        step(1'b0, 3'd0, 3'd0, 1'b1, 4'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic       v, r;
            logic [3:0] s;
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 99) == 0);
            s = {($urandom_range(0, 24) == 0), 3'($urandom_range(0, 7))};
            step(v, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), r, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
